fetch_prefetch_queue: RTL
=========================

Name: fetch_prefetch_queue

Overview:
Instruction fetch stage that drives the datapath instruction register and decode. It generates sequential word fetch addresses starting at the reset vector and issues one memory request at a time. Returned words and their PCs are buffered in a small FIFO. A branch redirects fetch and flushes all buffered and in-flight instructions.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
RESET_VECTOR, 32'hf0000000, first fetch address after reset

Ports:
clk  input  1  system clock, rising edge
clr_n  input  1  asynchronous active-low reset
mem_req  output  1  memory read request, registered
mem_addr  output  32  word address of request, registered, bits[1:0]=0
mem_ack  input  1  request complete; mem_rdata valid this cycle
mem_rdata  input  32  instruction word
branch_valid  input  1  redirect fetch (one-cycle pulse)
branch_target  input  32  redirect address; bits[1:0] ignored (forced 0)
ir_ready  input  1  consumer (IR load enable) accepts head this cycle
ir_valid  output  1  queue non-empty
ir_data  output  32  head instruction word
ir_pc  output  32  address of head instruction

Behaviour:
- Reset (clr_n=0, async): state=IDLE, mem_req=0, mem_addr=RESET_VECTOR, fetch_pc=RESET_VECTOR, count=0, rd/wr pointers=0, ir_valid=0. ir_data/ir_pc are don't-care while ir_valid=0. Reset mid-request abandons the request; memory must tolerate mem_req dropping.
- FIFO: DEPTH entries of {pc[31:0], data[31:0]}. Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits. ir_valid = (count!=0). ir_data/ir_pc are read combinationally from the head entry.
- Pop: ir_valid & ir_ready at a clock edge. ir_ready while empty is ignored.
- Push: an ack in WAIT writes {mem_addr, mem_rdata}. It becomes visible at ir_valid the cycle after the ack (1-cycle latency ack->ir_valid).
- Simultaneous push and pop: count unchanged. This is legal when full, because the pop frees the slot.
- Room rule: a new request may be issued only if (count after this edge's pop/push) < DEPTH. This guarantees the in-flight word always has a slot. Overflow is therefore impossible, and an assertion must check it.
- States:
  - IDLE: mem_req=0. If room and no branch, go to WAIT next edge with mem_req=1 and mem_addr=fetch_pc.
  - WAIT: mem_req=1 and mem_addr held stable until mem_ack. On mem_ack: push, fetch_pc<=mem_addr+4. If room remains, stay in WAIT with mem_addr=mem_addr+4 (back-to-back, no bubble); else go to IDLE with mem_req=0.
  - FLUSH: an in-flight request was killed by a branch. mem_req=1 with the old address held. On mem_ack: discard data and go to IDLE.
- Branch (highest priority):
  - Effects at the edge: count=0, pointers=0, fetch_pc<=branch_target&~3. Any same-cycle pop or push is discarded.
  - Next state by current state:
    - IDLE: goes to IDLE. The request to the target issues one cycle later.
    - WAIT without mem_ack: goes to FLUSH.
    - WAIT with same-cycle mem_ack: data dropped, goes to IDLE.
    - FLUSH without ack: stays in FLUSH with the new target latched.
    - FLUSH with ack: goes to IDLE.
- Address arithmetic: 32-bit, wraps 32'hfffffffc -> 32'h00000000 silently.
- Minimum branch-to-ir_valid latency when idle and memory acks in the first request cycle: 3 cycles (IDLE, WAIT/ack, push visible).

Test Plan:
- Reset/sequential: release clr_n, memory acks every request in its first cycle, ir_ready=1 -> mem_addr f0000000, f0000004, f0000008 on consecutive cycles; ir_pc/ir_data stream in order; no bubbles after the first.
- Fill/backpressure: ir_ready=0, memory always acks -> exactly DEPTH (4) pushes; mem_req drops after the 4th ack; ir_pc=f0000000 held. Raise ir_ready for 1 cycle -> one pop and a new request at f0000010.
- Full with simultaneous push/pop: count=3, request in flight, ack and pop in the same cycle -> count stays 3; order preserved.
- Branch during wait: request at f0000008 outstanding, branch_target=00001002 -> state FLUSH; mem_addr held f0000008 until ack. Acked data not enqueued; ir_valid=0. Next request at 00001000.
- Branch coincident with ack and pop: queue has 2 entries -> queue empty after the edge; acked word dropped; next fetch 00001000.
- Async reset mid-operation: assert clr_n low while in WAIT with count=2 -> mem_req=0, ir_valid=0 immediately (no clock). On release, fetch restarts at f0000000.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage: sequential word fetch with one outstanding request,
// a DEPTH-entry {pc,data} prefetch FIFO, and branch redirect with flush.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no request outstanding; issue at fetch_pc when room exists
// WAIT  | request at mem_addr outstanding; ack pushes the word
// FLUSH | request killed by a branch; ack is consumed and dropped
module fetch_prefetch_queue #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'hf0000000
) (
    input  logic        clk,
    input  logic        clr_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        ir_ready,
    output logic        ir_valid,
    output logic [31:0] ir_data,
    output logic [31:0] ir_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state_q;
    logic          mem_req_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   fetch_pc_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic          pop;
    logic          push;
    logic          push_ok;
    logic [CW-1:0] count_d;
    logic          room;
    logic [31:0]   target_w;
    logic [31:0]   next_addr;
    logic          unused_target_lsbs;

    assign unused_target_lsbs = ^branch_target[1:0];

    assign target_w  = {branch_target[31:2], 2'b00};
    assign next_addr = mem_addr_q + 32'd4;

    assign ir_valid = (count_q != '0);
    assign ir_data  = data_mem[rd_ptr_q];
    assign ir_pc    = pc_mem[rd_ptr_q];
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    assign pop     = ir_valid & ir_ready;
    assign push    = (state_q == WAIT) & mem_ack;
    assign push_ok = push & ~branch_valid;

    // Occupancy after this edge's pop/push decides whether a new request may go out,
    // which guarantees the in-flight word always has a free slot.
    assign count_d = count_q + CW'(push) - CW'(pop);
    assign room    = (count_d < DEPTH_C);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_VECTOR;
            fetch_pc_q <= RESET_VECTOR;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else if (branch_valid) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fetch_pc_q <= target_w;
            case (state_q)
                WAIT, FLUSH: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end else begin
                        state_q   <= FLUSH;
                        mem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end else begin
            count_q <= count_d;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            case (state_q)
                IDLE: begin
                    if (room) begin
                        state_q    <= WAIT;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        fetch_pc_q <= next_addr;
                        if (room) begin
                            mem_addr_q <= next_addr;
                        end else begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[wr_ptr_q]   <= mem_addr_q;
            data_mem[wr_ptr_q] <= mem_rdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!clr_n)
        !(push_ok && !pop && (count_q == DEPTH_C)));

endmodule
